mult_seq_ctrl: RTL and testbench

- Sequenced shift-and-add multiplier controller: one FSM owns a single 2W-bit accumulator/adder and computes a×b over WIDTH iterations.
- Replaces the array-of-adders multiplier where area matters; feeds the seven-segment display path (product nibbles to HEX2/HEX3, latched operands to HEX0/HEX1).
- start/busy/done handshake so a board-level wrapper or test FSM can issue operations.

---
 rtl/mult_seq_ctrl_if.sv | 36 +++
 rtl/mult_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_if
//   Handshake/data bundle between a requester (board wrapper, test FSM) and the
//   sequenced shift-and-add multiplier.
//
//   start   : requester -> multiplier, operation request
//   a, b    : requester -> multiplier, multiplicand / multiplier operands
//   busy    : multiplier -> requester, high while an operation is in flight
//   done    : multiplier -> requester, one-cycle pulse when product is valid
//   product : multiplier -> requester, a*b, held until the next result
//   op_a/b  : multiplier -> requester, operands latched at start acceptance
//
//   master modport = requester side, slave modport = multiplier side.
// -----------------------------------------------------------------------------
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;

    modport master (
        output start, a, b,
        input  busy, done, product, op_a, op_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, op_a, op_b
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//   Sequenced shift-and-add multiplier. One FSM drives a single 2*WIDTH-bit
//   accumulator and adder; a*b is produced after exactly WIDTH iterations.
//   Feeds the seven-segment path: product nibbles and the latched operands.
//
//   Ports:
//     clk   : system clock, rising-edge active
//     reset : asynchronous, active-high; clears all state and outputs
//     bus   : mult_seq_ctrl_if.slave
//               start/a/b in; busy/done/product/op_a/op_b out
//
//   Timing (start accepted at edge E0):
//     E1..EW   one iteration per edge, product loaded at EW
//     EW..EW+1 done high for one cycle
//     EW+1     back to IDLE; next start accepted at EW+2 at the earliest
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    mult_seq_ctrl_if.slave  bus
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PW-1:0]      acc;
    logic [PW-1:0]      acc_nxt;
    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;
    logic [PW-1:0]      product_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;

    logic               accept;
    logic               last_iter;

    // Partial product selected by the current low multiplier bit.
    function automatic logic [PW-1:0] partial(input logic [PW-1:0] m,
                                              input logic         sel);
        return sel ? m : '0;
    endfunction

    // Sum of 2*WIDTH bits never overflows: a*b < 2^(2*WIDTH).
    assign acc_nxt = acc + partial(mcand, mplier[0]);

    // ---- state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state decode ----
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // No early exit on mplier==0: latency stays fixed at WIDTH.
                if (count == CNT_W'(WIDTH - 1)) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- datapath: operand capture, iteration, result load ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            product_r <= '0;
            op_a_r    <= '0;
            op_b_r    <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            count  <= '0;
            op_a_r <= bus.a;
            op_b_r <= bus.b;
        end else if (state == RUN) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last_iter) begin
                product_r <= acc_nxt;
            end
        end
    end

    // ---- Moore outputs ----
    assign bus.busy    = (state == RUN) || (state == DONE);
    assign bus.done    = (state == DONE);
    assign bus.product = product_r;
    assign bus.op_a    = op_a_r;
    assign bus.op_b    = op_b_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
//   Self-checking bench for mult_seq_ctrl (WIDTH = 4). Directed table, handshake
//   corner sequences, randomized and exhaustive operand sweeps against a*b.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic clk;
    logic reset;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    logic [PW-1:0] prev_product;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] prod;
        bit            garble;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one operation from an idle negedge; returns at the negedge after
    // the DUT has dropped back to idle. garble drives start and random
    // operands on every busy cycle to show they are ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [PW-1:0] exp, input bit garble);
        int cyc;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        @(negedge clk);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("done_after_accept", 32'(bus.done), 32'd0);
        bus.start = garble;
        if (garble) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
        end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 3 * W) begin
            chk("product_hold", 32'(bus.product), 32'(prev_product));
            chk("op_a_hold", 32'(bus.op_a), 32'(ta));
            chk("op_b_hold", 32'(bus.op_b), 32'(tb_v));
            @(negedge clk);
            cyc++;
            if (garble) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
        end
        chk("latency", 32'(cyc), 32'(W));
        chk("product", 32'(bus.product), 32'(exp));
        chk("op_a", 32'(bus.op_a), 32'(ta));
        chk("op_b", 32'(bus.op_b), 32'(tb_v));
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        prev_product = exp;
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_pulse_end", 32'(bus.done), 32'd0);
        chk("busy_end", 32'(bus.busy), 32'd0);
        chk("product_after", 32'(bus.product), 32'(exp));
        if (garble) begin
            @(negedge clk);
            chk("no_queued_op", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int done_at[$];
        int low_cnt;
        int low_ok;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_cmp = 0;
        n_err = 0;
        prev_product = '0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  prod: 8'h0F, garble: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd15, prod: 8'hE1, garble: 1'b0};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  prod: 8'h00, garble: 1'b0};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  prod: 8'h00, garble: 1'b0};
        vecs[4] = '{a: 4'd7,  b: 4'd6,  prod: 8'h2A, garble: 1'b1};
        vecs[5] = '{a: 4'd1,  b: 4'd15, prod: 8'h0F, garble: 1'b0};

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_product", 32'(bus.product), 32'd0);
        chk("rst_op_a", 32'(bus.op_a), 32'd0);
        chk("rst_op_b", 32'(bus.op_b), 32'd0);
        reset = 1'b0;

        // Directed table; first entry launches on the first edge after release
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].garble);
        end

        // start tied high: done every W+2 cycles, busy low one cycle between
        bus.start = 1'b1;
        bus.a = 4'd4;
        bus.b = 4'd4;
        low_cnt = 0;
        low_ok = 1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_at.push_back(i);
                chk("tied_product", 32'(bus.product), 32'h10);
            end
            if (bus.busy === 1'b0) begin
                low_cnt++;
                if (done_at.size() == 0 || done_at[done_at.size()-1] != i - 1) low_ok = 0;
            end
        end
        bus.start = 1'b0;
        chk("tied_done_count", 32'(done_at.size()), 32'd3);
        if (done_at.size() == 3) begin
            chk("tied_first_done", 32'(done_at[0]), 32'(W + 1));
            chk("tied_interval1", 32'(done_at[1] - done_at[0]), 32'(W + 2));
            chk("tied_interval2", 32'(done_at[2] - done_at[1]), 32'(W + 2));
        end
        chk("tied_busy_low_cycles", 32'(low_cnt), 32'd3);
        chk("tied_busy_low_after_done", 32'(low_ok), 32'd1);
        prev_product = 8'h10;

        // Reset mid-RUN after E2: outputs clear before the next clock
        bus.start = 1'b1;
        bus.a = 4'd15;
        bus.b = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_done", 32'(bus.done), 32'd0);
        chk("async_product", 32'(bus.product), 32'd0);
        chk("async_op_a", 32'(bus.op_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_product = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_reset_no_done", 32'(bus.done), 32'd0);
        end
        chk("post_reset_idle", 32'(bus.busy), 32'd0);

        // Randomized operations with noise on inputs while busy
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, PW'(int'(ra) * int'(rb)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Exhaustive sweep of all operand pairs
        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                run_op(W'(x), W'(y), PW'(x * y), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
